from_ags_decoder: RTL and testbench

FROM_AGS_DECODER -- requirements
Module: from_ags_decoder

---
 rtl/ags_pkg.sv | 19 +
 rtl/ags_parity_acc.sv | 23 ++
 rtl/from_ags_decoder.sv | 101 ++++++++++
 tb/tb_from_ags_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ags_pkg.sv
// Shared types and constants for the AGS serial frame decoder.
package ags_pkg;

  // Decoder FSM states, one per frame field.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Line levels that delimit a frame.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Default payload width in bits.
  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/ags_parity_acc.sv
// Running even-parity accumulator: cleared on the start bit, folds in each
// data/parity bit; reads 0 at the stop bit when the frame parity is good.
module ags_parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic parity
);

  // XOR every enabled bit into the accumulator; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (clear) begin
      parity <= 1'b0;
    end else if (en) begin
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/from_ags_decoder.sv
// Serial frame decoder: start bit, DATA_W data bits LSB first, optional even
// parity bit, stop bit. One line sample per clock, no oversampling.
// Outputs are registered; the payload-valid, parity-error and framing-error
// strobes are mutually exclusive one-cycle pulses with no backpressure,
// asserted on the edge that samples the stop bit.
module from_ags_decoder
  import ags_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              __in0,
  output logic [DATA_W-1:0] __out0,
  output logic              __out1,
  output logic              __out2,
  output logic              __out3
);

  // Counter sized to index the payload; guarded for the 1-bit payload case.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // FSM state is kept as a named enum so checkers can bind to it directly.
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              parity;
  logic              parity_clear;
  logic              parity_en;
  logic              parity_ok;

  // Parity restarts on an accepted start bit and absorbs data + parity bits.
  assign parity_clear = (state == IDLE) && (__in0 == START_BIT);
  assign parity_en    = (state == DATA) || (state == PARITY);
  assign parity_ok    = (PARITY_EN == 0) || (parity == 1'b0);

  ags_parity_acc u_parity (
    .clk    (clk),
    .rst    (rst),
    .clear  (parity_clear),
    .en     (parity_en),
    .bit_in (__in0),
    .parity (parity)
  );

  // Frame FSM with registered payload and one-cycle result strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      __out0 <= '0;
      __out1 <= 1'b0;
      __out2 <= 1'b0;
      __out3 <= 1'b0;
    end else begin
      __out1 <= 1'b0;
      __out2 <= 1'b0;
      __out3 <= 1'b0;
      case (state)
        IDLE: begin
          if (__in0 == START_BIT) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          shreg[cnt] <= __in0;
          if (cnt == LAST_BIT) begin
            cnt   <= '0;
            state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          // The parity bit itself is absorbed by the accumulator.
          state <= STOP;
        end
        STOP: begin
          // A 0 here is a framing error, never a new start bit.
          if (__in0 == STOP_BIT) begin
            if (parity_ok) begin
              __out0 <= shreg;
              __out1 <= 1'b1;
            end else begin
              __out2 <= 1'b1;
            end
          end else begin
            __out3 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_from_ags_decoder.sv
// Directed bench for from_ags_decoder: default instance plus a
// parity-disabled instance, checked with immediate assertions.
module tb_from_ags_decoder;

  logic       clk;
  logic       rst;
  logic       in0;
  logic [7:0] out0;
  logic       out1;
  logic       out2;
  logic       out3;
  logic       in0_np;
  logic [7:0] out0_np;
  logic       out1_np;
  logic       out2_np;
  logic       out3_np;

  int tests_run;
  int tests_failed;

  from_ags_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .__in0  (in0),
    .__out0 (out0),
    .__out1 (out1),
    .__out2 (out2),
    .__out3 (out3)
  );

  from_ags_decoder #(.DATA_W(8), .PARITY_EN(0)) dut_np (
    .clk    (clk),
    .rst    (rst),
    .__in0  (in0_np),
    .__out0 (out0_np),
    .__out1 (out1_np),
    .__out2 (out2_np),
    .__out3 (out3_np)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one bit for the default DUT; returns 1 time unit after the sampling edge.
  task automatic drive_bit(input logic b);
    in0 = b;
    @(posedge clk);
    #1;
  endtask

  // Drive one bit for the parity-disabled DUT.
  task automatic drive_bit_np(input logic b);
    in0_np = b;
    @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, parity bit (stop bit driven by caller).
  task automatic send_body(input logic [7:0] d, input logic p);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    in0    = 1'b1;
    in0_np = 1'b1;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out0", out0, 8'h00);
    check("rst_strobes", {out1, out2, out3}, 3'b000);
    check("rst_state", dut.state, 2'd0);
    rst = 1'b0;

    // Valid 0xA5, even parity 0
    repeat (5) drive_bit(1'b1);
    send_body(8'hA5, 1'b0);
    check("a5_pre_stop_valid", out1, 1'b0);
    drive_bit(1'b1);
    check("a5_valid", out1, 1'b1);
    check("a5_data", out0, 8'hA5);
    check("a5_err", {out2, out3}, 2'b00);
    drive_bit(1'b1);
    check("a5_valid_one_cycle", out1, 1'b0);

    // 0x01 with wrong parity bit 0
    send_body(8'h01, 1'b0);
    drive_bit(1'b1);
    check("perr_strobe", out2, 1'b1);
    check("perr_no_valid", out1, 1'b0);
    check("perr_no_ferr", out3, 1'b0);
    check("perr_data_kept", out0, 8'hA5);
    drive_bit(1'b1);
    check("perr_one_cycle", out2, 1'b0);

    // 0x3C with stop bit 0, then a 1, then valid 0x77
    send_body(8'h3C, 1'b0);
    drive_bit(1'b0);
    check("ferr_strobe", out3, 1'b1);
    check("ferr_others", {out1, out2}, 2'b00);
    check("ferr_data_kept", out0, 8'hA5);
    drive_bit(1'b1);
    check("ferr_one_cycle", out3, 1'b0);
    check("ferr_back_idle", dut.state, 2'd0);
    send_body(8'h77, 1'b0);
    drive_bit(1'b1);
    check("x77_valid", out1, 1'b1);
    check("x77_data", out0, 8'h77);

    // Back-to-back 0x3C then 0xFF, no idle gap
    drive_bit(1'b1);
    send_body(8'h3C, 1'b0);
    drive_bit(1'b1);
    check("b2b_first_valid", out1, 1'b1);
    check("b2b_first_data", out0, 8'h3C);
    send_body(8'hFF, 1'b0);
    drive_bit(1'b1);
    check("b2b_second_valid", out1, 1'b1);
    check("b2b_second_data", out0, 8'hFF);
    check("b2b_second_err", {out2, out3}, 2'b00);

    // Reset mid-cycle during data bit 4 of 0xC3, then send 0x5A
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    in0 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out0", out0, 8'h00);
    check("midrst_strobes", {out1, out2, out3}, 3'b000);
    check("midrst_state", dut.state, 2'd0);
    @(posedge clk);
    #1;
    check("midrst_hold", {out0, out1, out2, out3}, 11'h000);
    rst = 1'b0;
    in0 = 1'b1;
    repeat (12) drive_bit(1'b1);
    check("abort_no_strobe", {out1, out2, out3}, 3'b000);
    send_body(8'h5A, 1'b0);
    drive_bit(1'b1);
    check("x5a_valid", out1, 1'b1);
    check("x5a_data", out0, 8'h5A);
    drive_bit(1'b1);

    // Parity disabled: 0x81, stop at edge 9
    drive_bit_np(1'b0);
    for (int i = 0; i < 8; i++) drive_bit_np(i == 0 || i == 7);
    check("np_pre_stop_valid", out1_np, 1'b0);
    drive_bit_np(1'b1);
    check("np_valid", out1_np, 1'b1);
    check("np_data", out0_np, 8'h81);
    check("np_err", {out2_np, out3_np}, 2'b00);
    drive_bit_np(1'b1);
    check("np_one_cycle", out1_np, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
